// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load/serial bus bundle for piso_serializer
//
// Groups every signal of the serializer except clk and reset.
//   d          : parallel word offered by the source (WIDTH bits)
//   load_valid : source has a word on d
//   load_ready : serializer can accept a word this cycle
//   lsb_first  : shift order for the word being loaded (1 = LSB first)
//   shift_en   : advance the serial stream this cycle
//   sout       : registered serial data bit
//   sout_valid : sout carries a frame bit
//   last       : sout is the final bit of the frame
//   busy       : a frame is in progress
//
// Modports:
//   master : the side that feeds words and paces the link
//   slave  : the serializer itself

interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             lsb_first;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             busy;

    modport master (
        output d,
        output load_valid,
        output lsb_first,
        output shift_en,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  last,
        input  busy
    );

    modport slave (
        input  d,
        input  load_valid,
        input  lsb_first,
        input  shift_en,
        output load_ready,
        output sout,
        output sout_valid,
        output last,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parametrised parallel-in/serial-out shift register
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per enabled clock, MSB-first or LSB-first, flagging the final bit and
// allowing back-to-back frames with no idle gap.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, clears all state immediately
//   bus    : piso_serializer_if.slave (d, load_valid, load_ready, lsb_first,
//            shift_en, sout, sout_valid, last, busy)
//
// Parameters:
//   WIDTH             : data word width, 2..32
//   LSB_FIRST_DEFAULT : 1 forces LSB-first regardless of bus.lsb_first
//
// Build option:
//   PISO_PARITY_EN : when defined, an even-parity bit (XOR of the data bits)
//                    follows the last data bit and carries the last flag.

module piso_serializer #(
    parameter int WIDTH             = 8,
    parameter bit LSB_FIRST_DEFAULT = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    piso_serializer_if.slave      bus
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_n;

    // The frame is stored already in transmit order: bit 0 of shreg is the
    // bit currently on sout, so shifting right exposes the next one. The
    // order choice is therefore captured in the layout at acceptance time
    // and needs no separate register.
    logic [FRAME_LEN-1:0] shreg;
    logic [FRAME_LEN-1:0] shreg_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;

    logic                 at_last;
    logic                 ready_c;
    logic                 accept;
    logic                 order_lsb;

    // Rearranges the incoming word so that the first bit to be transmitted
    // lands at index 0, and appends parity above the data when enabled.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic [WIDTH-1:0] w,
        input logic             lsb
    );
        logic [WIDTH-1:0] ordered;
        for (int i = 0; i < WIDTH; i++) begin
            ordered[i] = lsb ? w[i] : w[WIDTH-1-i];
        end
`ifdef PISO_PARITY_EN
        return {^w, ordered};
`else
        return ordered;
`endif
    endfunction

    assign at_last   = (state == SHIFT) && (cnt == LAST_IDX);
    assign order_lsb = bus.lsb_first | LSB_FIRST_DEFAULT;

    // Ready is combinational on shift_en so a new word can slip in on the
    // very edge that retires the final bit, giving gapless frames.
    assign ready_c = (state == IDLE) | (at_last & bus.shift_en);
    assign accept  = bus.load_valid & ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;

        // Acceptance wins over shift_en: a word is taken even on a stalled
        // cycle and its first bit then waits on sout.
        if (accept) begin
            state_n = SHIFT;
            shreg_n = build_frame(bus.d, order_lsb);
            cnt_n   = '0;
        end else if (state == SHIFT && bus.shift_en) begin
            if (at_last) begin
                // Clearing shreg keeps sout at 0 while idle.
                state_n = IDLE;
                shreg_n = '0;
                cnt_n   = '0;
            end else begin
                shreg_n = shreg >> 1;
                cnt_n   = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.load_ready = ready_c;
    assign bus.sout       = shreg[0];
    assign bus.sout_valid = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.last       = at_last;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register; the next generation of the team's 4-bit PISO.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, MSB-first or LSB-first.
- Flags the final bit of each frame and supports back-to-back frames with no idle gap.
- Sits between a parallel data source and a single-wire serial link or bit-level test driver.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- LSB_FIRST_DEFAULT, 0, shift order applied while the lsb_first input is tied to 0. A 1 makes the block always LSB-first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- d  input  WIDTH  parallel data word, sampled on load acceptance.
- load_valid  input  1  source has a word on d.
- load_ready  output  1  block can accept a word this cycle.
- lsb_first  input  1  order for the word being loaded: 1 = LSB first, 0 = MSB first. Sampled only at acceptance.
- shift_en  input  1  advance the serial stream this cycle; 0 stalls and holds all state.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit.
- last  output  1  sout is the final bit of the frame.
- busy  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Reset values: sout=0, sout_valid=0, last=0, busy=0, state=IDLE, bit counter=0, shift register=0. load_ready=1 once reset is released.
- Order applied to a frame = lsb_first OR LSB_FIRST_DEFAULT, latched at acceptance.
- States:
  - IDLE: sout_valid=0, sout=0.
  - SHIFT: sout_valid=1, busy=1.
- Handshake: acceptance = load_valid & load_ready, evaluated at the rising edge. d is ignored on any cycle without acceptance.
- load_ready = (state==IDLE) | (state==SHIFT & last & shift_en). It is combinational from state and shift_en.
- Acceptance has priority over shift_en: a word is accepted even if shift_en=0 that cycle. The first bit then waits on the output.
- Latency: on the edge that accepts a word, state goes to SHIFT and sout drives bit 0 of the frame from the next cycle. Bit 0 is d[WIDTH-1] for MSB-first, d[0] for LSB-first.
- Shifting:
  - Each edge with state=SHIFT and shift_en=1 advances sout to the next bit and increments the counter.
  - With shift_en=0, sout, counter and last hold.
  - Each bit is presented for at least one cycle and exactly one enabled edge.
- last=1 while the counter equals FRAME_LEN-1, where FRAME_LEN=WIDTH (WIDTH+1 with parity).
- Final bit, shift_en=1, no acceptance: go to IDLE; sout_valid and last drop at that edge.
- Final bit, shift_en=1, acceptance: the new word loads and its bit 0 appears the next cycle. No gap; sout_valid stays 1.
- Reset mid-frame: the frame is aborted and outputs go to reset values asynchronously. After release, the block restarts in IDLE with no residual bits.
- A load_valid pulse arriving during a frame, other than on the final enabled bit, is not accepted; the source must hold it.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the last data bit regardless of shift order.
  - FRAME_LEN=WIDTH+1; last flags the parity bit, not the final data bit.
  - load_ready back-to-back timing moves to the parity bit.
- Undefined: no parity bit, FRAME_LEN=WIDTH, and no parity logic is synthesised.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles, then release. All outputs 0, load_ready=1. Pulse reset=0 for half a cycle mid-frame: outputs clear before the next edge.
2. MSB-first, WIDTH=4, shift_en=1: accept d=4'b0100, lsb_first=0. sout over 4 cycles = 0,1,0,0; last=1 only on the 4th bit; busy=0 the cycle after.
3. LSB-first, WIDTH=4: accept d=4'b1110, lsb_first=1. sout = 0,1,1,1, then the block returns to IDLE.
4. Back-to-back, WIDTH=4: hold load_valid=1 with d=4'b1010 then 4'b0011 (MSB-first). sout = 1,0,1,0,0,0,1,1 with sout_valid continuously 1. last pulses on bits 4 and 8; load_ready high only on those cycles.
5. Stall, WIDTH=8, d=8'hA5 MSB-first: drop shift_en for 3 cycles after bit 2. sout holds 1 and last stays 0 during the stall. The full stream is 1,0,1,0,0,1,0,1; a load_valid asserted during the stall is not accepted.
6. With PISO_PARITY_EN, WIDTH=4, d=4'b0111: sout = 0,1,1,1,1 (parity 1), last on the 5th bit. With d=4'b0110 the parity bit is 0.
